hsv_color_tracker: RTL and testbench

Streaming colour-segmentation and centroid stage placed directly downstream of the RGB-to-HSV converter in the DE2 camera path. Each valid HSV pixel is classified against a hue/saturation/value window, producing a per-pixel mask. Matching pixel coordinates are accumulated over one frame. At frame end, a sequential divider produces the blob centroid and pixel count for the game/overlay logic.

---
 rtl/hsv_color_tracker.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_hsv_color_tracker.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_color_tracker.sv
// HSV window classifier with per-frame blob centroid from a sequential restoring divider.
// Optional bounding-box outputs are compiled in with `define TRACKER_BBOX_EN.
module hsv_color_tracker #(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int ACC_W     = 32,
  parameter int MIN_COUNT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  h_in,
  input  logic [7:0]  s_in,
  input  logic [7:0]  v_in,
  input  logic        valid_in,
  input  logic        frame_start,
  input  logic [8:0]  h_lo,
  input  logic [8:0]  h_hi,
  input  logic [7:0]  s_min,
  input  logic [7:0]  v_min,
  output logic        mask_out,
  output logic        mask_valid,
  output logic [8:0]  cx,
  output logic [7:0]  cy,
  output logic [16:0] count,
  output logic        found,
  output logic        result_valid,
  output logic        overrun,
`ifdef TRACKER_BBOX_EN
  output logic [8:0]  bb_xmin,
  output logic [8:0]  bb_xmax,
  output logic [7:0]  bb_ymin,
  output logic [7:0]  bb_ymax,
`endif
  output logic [1:0]  dbg_state
);

  // valid_in qualifies one pixel per cycle; there is no back-pressure, so every
  // valid pixel is consumed on the edge where valid_in is high.

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

  localparam int              SW        = $clog2(ACC_W);
  localparam logic [8:0]      X_LAST    = 9'(IMG_W - 1);
  localparam logic [7:0]      Y_LAST    = 8'(IMG_H - 1);
  localparam logic [16:0]     MIN_C     = 17'(MIN_COUNT);
  localparam logic [SW-1:0]   STEP_LAST = SW'(ACC_W - 1);

  // pixel-side state
  logic [8:0]       x_q;
  logic [7:0]       y_q;
  logic             active_q;
  logic [8:0]       h_lo_q, h_hi_q;
  logic [7:0]       s_min_q, v_min_q;
  logic [ACC_W-1:0] sum_x_q, sum_y_q;
  logic [16:0]      cnt_q;

  logic             fs, accept, hue_ok, match, hit, last_px;
  logic [8:0]       cur_x, eh_lo, eh_hi;
  logic [7:0]       cur_y, es_min, ev_min;
  logic [ACC_W-1:0] base_sx, base_sy, nxt_sx, nxt_sy;
  logic [16:0]      base_cnt, nxt_cnt;

  // divider-side state
  state_t           state_q;
  logic             go_q;
  logic [ACC_W-1:0] sh_sx, sh_sy;
  logic [16:0]      sh_cnt;
  logic [ACC_W-1:0] dvd_q, rem_q;
  logic [7:0]       quo_q;
  logic [SW-1:0]    step_q;
  logic [8:0]       qx_q;
  logic [7:0]       qy_q;

  logic [ACC_W:0]   rem_sh;
  logic [ACC_W-1:0] dvs, rem_nxt;
  logic             ge, busy, div_ok;

`ifdef TRACKER_BBOX_EN
  logic [8:0] bx_min_q, bx_max_q, sh_xmin, sh_xmax;
  logic [7:0] by_min_q, by_max_q, sh_ymin, sh_ymax;
  logic [8:0] base_xmin, base_xmax, nxt_xmin, nxt_xmax;
  logic [7:0] base_ymin, base_ymax, nxt_ymin, nxt_ymax;
  logic       first_hit;
`endif

  assign dbg_state = state_q;

  always_comb begin
    fs      = valid_in & frame_start;
    accept  = valid_in & (fs | active_q);
    cur_x   = fs ? 9'd0 : x_q;
    cur_y   = fs ? 8'd0 : y_q;
    // the first pixel of a frame is classified with the thresholds being latched
    eh_lo   = fs ? h_lo  : h_lo_q;
    eh_hi   = fs ? h_hi  : h_hi_q;
    es_min  = fs ? s_min : s_min_q;
    ev_min  = fs ? v_min : v_min_q;
    if (eh_lo <= eh_hi) hue_ok = (h_in >= eh_lo) && (h_in <= eh_hi);
    else                hue_ok = (h_in >= eh_lo) || (h_in <= eh_hi);
    match    = hue_ok && (s_in >= es_min) && (v_in >= ev_min);
    hit      = accept & match;
    last_px  = accept && (cur_x == X_LAST) && (cur_y == Y_LAST);
    base_sx  = fs ? '0 : sum_x_q;
    base_sy  = fs ? '0 : sum_y_q;
    base_cnt = fs ? '0 : cnt_q;
    nxt_sx   = base_sx + (hit ? {{(ACC_W-9){1'b0}}, cur_x} : '0);
    nxt_sy   = base_sy + (hit ? {{(ACC_W-8){1'b0}}, cur_y} : '0);
    nxt_cnt  = base_cnt + {16'd0, hit};
  end

`ifdef TRACKER_BBOX_EN
  always_comb begin
    base_xmin = fs ? 9'd0 : bx_min_q;
    base_xmax = fs ? 9'd0 : bx_max_q;
    base_ymin = fs ? 8'd0 : by_min_q;
    base_ymax = fs ? 8'd0 : by_max_q;
    first_hit = (base_cnt == 17'd0);
    nxt_xmin  = base_xmin;
    nxt_xmax  = base_xmax;
    nxt_ymin  = base_ymin;
    nxt_ymax  = base_ymax;
    if (hit) begin
      if (first_hit || (cur_x < base_xmin)) nxt_xmin = cur_x;
      if (first_hit || (cur_x > base_xmax)) nxt_xmax = cur_x;
      if (first_hit || (cur_y < base_ymin)) nxt_ymin = cur_y;
      if (first_hit || (cur_y > base_ymax)) nxt_ymax = cur_y;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      active_q   <= 1'b0;
      h_lo_q     <= '0;
      h_hi_q     <= '0;
      s_min_q    <= '0;
      v_min_q    <= '0;
      sum_x_q    <= '0;
      sum_y_q    <= '0;
      cnt_q      <= '0;
      mask_out   <= 1'b0;
      mask_valid <= 1'b0;
`ifdef TRACKER_BBOX_EN
      bx_min_q   <= '0;
      bx_max_q   <= '0;
      by_min_q   <= '0;
      by_max_q   <= '0;
`endif
    end else begin
      mask_valid <= valid_in;
      mask_out   <= valid_in & match;
      if (fs) begin
        h_lo_q  <= h_lo;
        h_hi_q  <= h_hi;
        s_min_q <= s_min;
        v_min_q <= v_min;
      end
      if (accept) begin
        if (last_px) begin
          // frame totals have been handed to the divider; idle until next frame_start
          x_q      <= '0;
          y_q      <= '0;
          active_q <= 1'b0;
          sum_x_q  <= '0;
          sum_y_q  <= '0;
          cnt_q    <= '0;
`ifdef TRACKER_BBOX_EN
          bx_min_q <= '0;
          bx_max_q <= '0;
          by_min_q <= '0;
          by_max_q <= '0;
`endif
        end else begin
          active_q <= 1'b1;
          if (cur_x == X_LAST) begin
            x_q <= '0;
            y_q <= cur_y + 8'd1;
          end else begin
            x_q <= cur_x + 9'd1;
            y_q <= cur_y;
          end
          sum_x_q  <= nxt_sx;
          sum_y_q  <= nxt_sy;
          cnt_q    <= nxt_cnt;
`ifdef TRACKER_BBOX_EN
          bx_min_q <= nxt_xmin;
          bx_max_q <= nxt_xmax;
          by_min_q <= nxt_ymin;
          by_max_q <= nxt_ymax;
`endif
        end
      end
    end
  end

  // Restoring step. The remainder never exceeds the divisor, so the carry-out bit
  // of the shifted remainder is folded into the compare and the subtraction wraps.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[ACC_W-1]};
    dvs     = {{(ACC_W-17){1'b0}}, sh_cnt};
    ge      = rem_sh[ACC_W] | (rem_sh[ACC_W-1:0] >= dvs);
    rem_nxt = ge ? (rem_sh[ACC_W-1:0] - dvs) : rem_sh[ACC_W-1:0];
    busy    = (state_q != IDLE) | go_q;
    div_ok  = (sh_cnt >= MIN_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      go_q         <= 1'b0;
      sh_sx        <= '0;
      sh_sy        <= '0;
      sh_cnt       <= '0;
      dvd_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      step_q       <= '0;
      qx_q         <= '0;
      qy_q         <= '0;
      cx           <= '0;
      cy           <= '0;
      count        <= '0;
      found        <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
`ifdef TRACKER_BBOX_EN
      sh_xmin      <= '0;
      sh_xmax      <= '0;
      sh_ymin      <= '0;
      sh_ymax      <= '0;
      bb_xmin      <= '0;
      bb_xmax      <= '0;
      bb_ymin      <= '0;
      bb_ymax      <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      if (last_px) begin
        if (busy) begin
          overrun <= 1'b1;
        end else begin
          sh_sx   <= nxt_sx;
          sh_sy   <= nxt_sy;
          sh_cnt  <= nxt_cnt;
          go_q    <= 1'b1;
`ifdef TRACKER_BBOX_EN
          sh_xmin <= nxt_xmin;
          sh_xmax <= nxt_xmax;
          sh_ymin <= nxt_ymin;
          sh_ymax <= nxt_ymax;
`endif
        end
      end
      case (state_q)
        IDLE: begin
          if (go_q) begin
            go_q <= 1'b0;
            if (!div_ok) begin
              state_q <= DONE;
            end else begin
              state_q <= DIV_X;
              dvd_q   <= sh_sx;
              rem_q   <= '0;
              quo_q   <= '0;
              step_q  <= '0;
            end
          end
        end
        DIV_X: begin
          rem_q  <= rem_nxt;
          quo_q  <= {quo_q[6:0], ge};
          dvd_q  <= {dvd_q[ACC_W-2:0], 1'b0};
          step_q <= step_q + 1'b1;
          if (step_q == STEP_LAST) begin
            qx_q    <= {quo_q, ge};
            state_q <= DIV_Y;
            dvd_q   <= sh_sy;
            rem_q   <= '0;
            quo_q   <= '0;
            step_q  <= '0;
          end
        end
        DIV_Y: begin
          rem_q  <= rem_nxt;
          quo_q  <= {quo_q[6:0], ge};
          dvd_q  <= {dvd_q[ACC_W-2:0], 1'b0};
          step_q <= step_q + 1'b1;
          if (step_q == STEP_LAST) begin
            qy_q    <= {quo_q[6:0], ge};
            state_q <= DONE;
          end
        end
        DONE: begin
          cx           <= div_ok ? qx_q : 9'd0;
          cy           <= div_ok ? qy_q : 8'd0;
          count        <= sh_cnt;
          found        <= div_ok;
          result_valid <= 1'b1;
          state_q      <= IDLE;
`ifdef TRACKER_BBOX_EN
          bb_xmin      <= div_ok ? sh_xmin : 9'd0;
          bb_xmax      <= div_ok ? sh_xmax : 9'd0;
          bb_ymin      <= div_ok ? sh_ymin : 8'd0;
          bb_ymax      <= div_ok ? sh_ymax : 8'd0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hsv_color_tracker.sv
// Bench for hsv_color_tracker on a reduced 112x60 frame: mask vector table,
// frame-level scoreboard for centroid results, and reset/restart sequences.
module tb_hsv_color_tracker;

  localparam int W    = 112;
  localparam int H    = 60;
  localparam int ACC  = 32;
  localparam int MINC = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  h_in = '0, h_lo = '0, h_hi = '0;
  logic [7:0]  s_in = '0, v_in = '0, s_min = '0, v_min = '0;
  logic        valid_in = 1'b0, frame_start = 1'b0;
  logic        mask_out, mask_valid, found, result_valid, overrun;
  logic [8:0]  cx;
  logic [7:0]  cy;
  logic [16:0] count;
  logic [1:0]  dbg_state;
`ifdef TRACKER_BBOX_EN
  logic [8:0]  bb_xmin, bb_xmax;
  logic [7:0]  bb_ymin, bb_ymax;
`endif

  hsv_color_tracker #(.IMG_W(W), .IMG_H(H), .ACC_W(ACC), .MIN_COUNT(MINC)) dut (
    .clk(clk), .rst_n(rst_n), .h_in(h_in), .s_in(s_in), .v_in(v_in),
    .valid_in(valid_in), .frame_start(frame_start),
    .h_lo(h_lo), .h_hi(h_hi), .s_min(s_min), .v_min(v_min),
    .mask_out(mask_out), .mask_valid(mask_valid), .cx(cx), .cy(cy),
    .count(count), .found(found), .result_valid(result_valid), .overrun(overrun),
`ifdef TRACKER_BBOX_EN
    .bb_xmin(bb_xmin), .bb_xmax(bb_xmax), .bb_ymin(bb_ymin), .bb_ymax(bb_ymax),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic vin_d;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) vin_d <= 1'b0;
    else        vin_d <= valid_in;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", 1);
    $fatal(1, "watchdog");
  end

  // scoreboard
  typedef struct packed {
    logic [16:0] cnt;
    logic [8:0]  cx;
    logic [7:0]  cy;
    logic        found;
    logic [8:0]  bxmin;
    logic [8:0]  bxmax;
    logic [7:0]  bymin;
    logic [7:0]  bymax;
    logic [31:0] cyc;
  } res_t;
  localparam int RES_W = $bits(res_t);

  logic [RES_W-1:0] exp_q[$];
  logic             mask_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    res_t r;
    logic m;
    if (rst_n) begin
      chk("mask_valid", {31'd0, mask_valid}, {31'd0, vin_d});
      if (mask_valid) begin
        if (mask_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mask_unexpected actual=%0d required=no mask", mask_out);
        end else begin
          m = mask_q.pop_front();
          chk("mask_out", {31'd0, mask_out}, {31'd0, m});
        end
      end
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL result_unexpected actual=pulse count=%0d required=no pulse", count);
        end else begin
          r = exp_q.pop_front();
          chk("res_latency", cyc, r.cyc);
          chk("res_count", {15'd0, count}, {15'd0, r.cnt});
          chk("res_cx", {23'd0, cx}, {23'd0, r.cx});
          chk("res_cy", {24'd0, cy}, {24'd0, r.cy});
          chk("res_found", {31'd0, found}, {31'd0, r.found});
`ifdef TRACKER_BBOX_EN
          chk("res_bb_xmin", {23'd0, bb_xmin}, {23'd0, r.bxmin});
          chk("res_bb_xmax", {23'd0, bb_xmax}, {23'd0, r.bxmax});
          chk("res_bb_ymin", {24'd0, bb_ymin}, {24'd0, r.bymin});
          chk("res_bb_ymax", {24'd0, bb_ymax}, {24'd0, r.bymax});
`endif
        end
      end
    end
  end

  // reference classifier
  function automatic logic px_match(input logic [8:0] h, input logic [7:0] s, input logic [7:0] v,
                                    input logic [8:0] lo, input logic [8:0] hi,
                                    input logic [7:0] smin, input logic [7:0] vmin);
    logic hok;
    if (lo <= hi) hok = (h >= lo) && (h <= hi);
    else          hok = (h >= lo) || (h <= hi);
    return hok && (s >= smin) && (v >= vmin);
  endfunction

  // driver tasks
  task automatic drive_px(input logic [8:0] h, input logic [7:0] s, input logic [7:0] v,
                          input logic fs, input logic [8:0] lo, input logic [8:0] hi,
                          input logic [7:0] smin, input logic [7:0] vmin, input logic em);
    @(negedge clk);
    h_in = h; s_in = s; v_in = v;
    h_lo = lo; h_hi = hi; s_min = smin; v_min = vmin;
    frame_start = fs;
    valid_in = 1'b1;
    mask_q.push_back(em);
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    valid_in = 1'b0;
    frame_start = 1'b0;
    h_in = 9'($urandom_range(359));
    s_in = 8'($urandom_range(255));
    v_in = 8'($urandom_range(255));
  endtask

  // pat 0: solid red, wrap window; pat 1: 10x10 block; pat 2: 8 matching pixels
  task automatic run_frame(input int pat, input int gap_pct, input int stop_at);
    logic [8:0] lo, hi, h;
    logic [7:0] smin, vmin, s, v;
    logic       m, inb;
    longint     sx, sy;
    int         n, idx, lat;
    int         xmin, xmax, ymin, ymax;
    res_t       r;
    sx = 0; sy = 0; n = 0; xmin = 0; xmax = 0; ymin = 0; ymax = 0;
    if (pat == 0) begin lo = 9'd350; hi = 9'd10;  end
    else          begin lo = 9'd100; hi = 9'd140; end
    smin = 8'd100; vmin = 8'd100;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        idx = y * W + x;
        if (idx == stop_at) begin
          idle_cyc();
          return;
        end
        while ($urandom_range(99) < gap_pct) idle_cyc();
        if (pat == 0) begin
          h = 9'd0; s = 8'd255; v = 8'd255;
        end else begin
          if (pat == 1) inb = (x >= 100) && (x <= 109) && (y >= 50) && (y <= 59);
          else          inb = (y == 5) && (x < 8);
          h = 9'd120; s = inb ? 8'd200 : 8'd0; v = inb ? 8'd200 : 8'd128;
        end
        m = px_match(h, s, v, lo, hi, smin, vmin);
        if (idx == 0)
          drive_px(h, s, v, 1'b1, lo, hi, smin, vmin, m);
        else
          drive_px(h, s, v, 1'b0, 9'($urandom_range(359)), 9'($urandom_range(359)),
                   8'($urandom_range(255)), 8'($urandom_range(255)), m);
        if (m) begin
          if (n == 0) begin xmin = x; xmax = x; ymin = y; ymax = y; end
          if (x < xmin) xmin = x;
          if (x > xmax) xmax = x;
          if (y < ymin) ymin = y;
          if (y > ymax) ymax = y;
          sx += x; sy += y; n++;
        end
        if (idx == W * H - 1) begin
          lat = (n >= MINC) ? 2 * ACC + 2 : 2;
          r.cnt   = 17'(n);
          r.found = (n >= MINC);
          r.cx    = r.found ? 9'(sx / n) : 9'd0;
          r.cy    = r.found ? 8'(sy / n) : 8'd0;
          r.bxmin = r.found ? 9'(xmin) : 9'd0;
          r.bxmax = r.found ? 9'(xmax) : 9'd0;
          r.bymin = r.found ? 8'(ymin) : 8'd0;
          r.bymax = r.found ? 8'(ymax) : 8'd0;
          r.cyc   = 32'(cyc + 1 + lat);
          exp_q.push_back(r);
        end
      end
    end
    idle_cyc();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    valid_in = 1'b0;
    frame_start = 1'b0;
    exp_q.delete();
    mask_q.delete();
    repeat (3) @(negedge clk);
    chk("reset_result_valid", {31'd0, result_valid}, 32'd0);
    chk("reset_count", {15'd0, count}, 32'd0);
    chk("reset_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
  endtask

  // mask classification vectors
  typedef struct {
    logic [8:0] h;
    logic [7:0] s;
    logic [7:0] v;
    logic [8:0] lo;
    logic [8:0] hi;
    logic [7:0] smin;
    logic [7:0] vmin;
    logic       exp_m;
  } mvec_t;
  mvec_t mv[16];

  initial begin
    mv[0]  = '{9'd0,   8'd255, 8'd255, 9'd350, 9'd10,  8'd100, 8'd100, 1'b1};
    mv[1]  = '{9'd359, 8'd255, 8'd255, 9'd350, 9'd10,  8'd100, 8'd100, 1'b1};
    mv[2]  = '{9'd350, 8'd255, 8'd255, 9'd350, 9'd10,  8'd100, 8'd100, 1'b1};
    mv[3]  = '{9'd10,  8'd255, 8'd255, 9'd350, 9'd10,  8'd100, 8'd100, 1'b1};
    mv[4]  = '{9'd11,  8'd255, 8'd255, 9'd350, 9'd10,  8'd100, 8'd100, 1'b0};
    mv[5]  = '{9'd349, 8'd255, 8'd255, 9'd350, 9'd10,  8'd100, 8'd100, 1'b0};
    mv[6]  = '{9'd120, 8'd200, 8'd200, 9'd100, 9'd140, 8'd100, 8'd100, 1'b1};
    mv[7]  = '{9'd100, 8'd200, 8'd200, 9'd100, 9'd140, 8'd100, 8'd100, 1'b1};
    mv[8]  = '{9'd140, 8'd200, 8'd200, 9'd100, 9'd140, 8'd100, 8'd100, 1'b1};
    mv[9]  = '{9'd141, 8'd200, 8'd200, 9'd100, 9'd140, 8'd100, 8'd100, 1'b0};
    mv[10] = '{9'd99,  8'd200, 8'd200, 9'd100, 9'd140, 8'd100, 8'd100, 1'b0};
    mv[11] = '{9'd120, 8'd99,  8'd200, 9'd100, 9'd140, 8'd100, 8'd100, 1'b0};
    mv[12] = '{9'd120, 8'd100, 8'd200, 9'd100, 9'd140, 8'd100, 8'd100, 1'b1};
    mv[13] = '{9'd120, 8'd200, 8'd99,  9'd100, 9'd140, 8'd100, 8'd100, 1'b0};
    mv[14] = '{9'd120, 8'd200, 8'd100, 9'd100, 9'd140, 8'd100, 8'd100, 1'b1};
    mv[15] = '{9'd0,   8'd0,   8'd0,   9'd0,   9'd0,   8'd0,   8'd0,   1'b1};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_mask_valid", {31'd0, mask_valid}, 32'd0);
    chk("rst_mask_out", {31'd0, mask_out}, 32'd0);
    chk("rst_count", {15'd0, count}, 32'd0);
    chk("rst_cx", {23'd0, cx}, 32'd0);
    chk("rst_cy", {24'd0, cy}, 32'd0);
    chk("rst_found", {31'd0, found}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    idle_cyc();

    // classification table, each vector a fresh one-pixel frame
    for (int i = 0; i < 16; i++)
      drive_px(mv[i].h, mv[i].s, mv[i].v, 1'b1, mv[i].lo, mv[i].hi,
               mv[i].smin, mv[i].vmin, mv[i].exp_m);
    idle_cyc();

    // thresholds stay latched after frame_start
    drive_px(9'd120, 8'd200, 8'd200, 1'b1, 9'd100, 9'd140, 8'd100, 8'd100, 1'b1);
    drive_px(9'd120, 8'd200, 8'd200, 1'b0, 9'd0,   9'd10,  8'd250, 8'd250, 1'b1);
    drive_px(9'd5,   8'd200, 8'd200, 1'b0, 9'd0,   9'd10,  8'd0,   8'd0,   1'b0);
    idle_cyc();

    run_frame(0, 0, -1);      // solid, wrap window
    run_frame(1, 0, -1);      // 10x10 block
    run_frame(2, 0, -1);      // below MIN_COUNT, short latency
    run_frame(1, 0, 5000);    // abandoned partial frame
    run_frame(0, 0, -1);
    run_frame(1, 50, -1);     // gappy valid_in

    // reset in the middle of a division, then two clean frames
    run_frame(1, 0, -1);
    repeat (20) idle_cyc();
    do_reset();
    repeat (5) idle_cyc();
    run_frame(0, 0, -1);
    run_frame(1, 0, -1);

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    chk("results_outstanding", exp_q.size(), 32'd0);
    chk("end_overrun", {31'd0, overrun}, 32'd0);
    repeat (2) idle_cyc();
    chk("masks_outstanding", mask_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
